// File: rtl/token_dispatcher.sv
// Token dispatcher: credit-limited reads from a token buffer into a FWFT return FIFO.
// Optional issue-stall counter enabled by defining TOKEN_DISP_PERF_EN.
module token_dispatcher #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic [ADDR_WIDTH-1:0] in_base_addr,
    input  logic [ADDR_WIDTH:0]   in_num_tokens,
    input  logic                  in_grant,
    output logic                  out_disp_req,
    output logic [ADDR_WIDTH-1:0] out_disp_addr,
    input  logic [DATA_WIDTH-1:0] in_disp_rdata,
    input  logic                  in_disp_rdata_valid,
    output logic                  out_tok_valid,
    output logic [DATA_WIDTH-1:0] out_tok_data,
    output logic                  out_tok_last,
    input  logic                  in_tok_ready,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [15:0]           out_perf_stall_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [NW-1:0]         num, issued, popped;
    logic [CW-1:0]         outst, occ;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CW:0]           credit;
    logic                  active, push, pop, start_ok, last_req;

    assign active   = (state == ISSUE) || (state == DRAIN);
    assign credit   = {1'b0, outst} + {1'b0, occ};
    assign start_ok = (state == IDLE) && in_start;

    // Credits cover both in-flight reads and queued tokens, so the FIFO never overflows
    assign out_disp_req  = (state == ISSUE) && in_grant &&
                           (credit < (CW+1)'(FIFO_DEPTH));
    assign out_disp_addr = base + issued[ADDR_WIDTH-1:0];
    assign last_req      = out_disp_req && (issued == num - NW'(1));

    // Responses are only accepted while a job is live; stale ones after reset are dropped
    assign push          = in_disp_rdata_valid && active;
    assign out_tok_valid = (occ != '0);
    assign pop           = out_tok_valid && in_tok_ready;
    assign out_tok_data  = out_tok_valid ? mem[rd_ptr] : '0;
    assign out_tok_last  = out_tok_valid && (popped == num - NW'(1));

    assign out_busy = active;
    assign out_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_start)
                    state_nxt = (in_num_tokens != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                if (last_req)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && out_tok_last)
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base   <= '0;
            num    <= '0;
            issued <= '0;
            popped <= '0;
            outst  <= '0;
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (start_ok && in_num_tokens != '0) begin
            base   <= in_base_addr;
            num    <= in_num_tokens;
            issued <= '0;
            popped <= '0;
            outst  <= '0;
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (out_disp_req)
                issued <= issued + NW'(1);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                popped <= popped + NW'(1);
            end
            case ({out_disp_req, push})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_disp_rdata;
    end

`ifdef TOKEN_DISP_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (start_ok)
            stall_cnt <= '0;
        else if (state == ISSUE && !out_disp_req && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign out_perf_stall_cnt = stall_cnt;
`else
    assign out_perf_stall_cnt = '0;
`endif

endmodule

// File: doc/token_dispatcher.md
TOKEN_DISPATCHER -- requirements
Module: token_dispatcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 8, token buffer address width.
REQ-002 SHALL have parameter DATA_WIDTH, 1024, token width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, return FIFO entries (power of 2, >=2).
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous and active-high.
- in_start  in  1  one-cycle job start pulse.
- in_base_addr  in  ADDR_WIDTH  first token address.
- in_num_tokens  in  ADDR_WIDTH+1  token count, 0..256.
- in_grant  in  1  buffer port currently selected for dispatcher.
- out_disp_req  out  1  read request to token buffer.
- out_disp_addr  out  ADDR_WIDTH  read address.
- in_disp_rdata  in  DATA_WIDTH  returned token.
- in_disp_rdata_valid  in  1  returned token valid.
- out_tok_valid  out  1  downstream token valid.
- out_tok_data  out  DATA_WIDTH  downstream token.
- out_tok_last  out  1  marks final token of job.
- in_tok_ready  in  1  downstream accept.
- out_busy  out  1  job in progress.
- out_done  out  1  one-cycle job-complete pulse.
- out_perf_stall_cnt  out  16  issue-stall counter (see Configuration).

Function
REQ-005 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE; IDLE on reset.
REQ-006 IDLE: in_start with in_num_tokens>0 SHALL latch base/count, clear counters, go ISSUE; with in_num_tokens==0 SHALL go DONE.
REQ-007 in_start outside IDLE SHALL be ignored.
REQ-008 ISSUE: out_disp_req SHALL be 1 in a cycle iff in_grant==1 and (outstanding + FIFO occupancy) < FIFO_DEPTH; requests SHALL be combinational from registered state.
REQ-009 out_disp_addr SHALL be in_base_addr + issued_count modulo 2^ADDR_WIDTH (255 wraps to 0).
REQ-010 ISSUE SHALL go DRAIN in the cycle after the last request issues.
REQ-011 outstanding SHALL increment per issued request and decrement per in_disp_rdata_valid; both in one cycle leave it unchanged.
REQ-012 Each in_disp_rdata_valid SHALL write in_disp_rdata into the FIFO that cycle; credit rule SHALL guarantee no overflow; arrival latency SHALL not be assumed (data-valid driven only).
REQ-013 out_tok_valid SHALL equal FIFO non-empty; out_tok_data SHALL be FIFO head (first-word fall-through); pop on out_tok_valid & in_tok_ready.
REQ-014 Simultaneous push and pop SHALL keep occupancy unchanged, including push into a full-minus-pop FIFO and push into an empty FIFO (token visible next cycle).
REQ-015 out_tok_last SHALL be 1 with out_tok_valid when the head is the in_num_tokens-th token of the job.
REQ-016 DRAIN SHALL go DONE when last token is popped; DONE SHALL assert out_done for one cycle and return to IDLE.
REQ-017 out_busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
REQ-018 Token order at out_tok_data SHALL equal request address order.

Reset
REQ-019 rst SHALL asynchronously force: IDLE, counters and FIFO pointers 0, out_disp_req 0, out_disp_addr 0, out_tok_valid 0, out_tok_data 0, out_tok_last 0, out_busy 0, out_done 0, out_perf_stall_cnt 0.
REQ-020 Reset mid-job SHALL abort the job; responses arriving after reset release while IDLE SHALL be dropped.

Configuration
REQ-021 Macro TOKEN_DISP_PERF_EN defined: out_perf_stall_cnt SHALL increment (saturating at 0xFFFF) each ISSUE cycle with out_disp_req==0, cleared on accepted in_start.
REQ-022 TOKEN_DISP_PERF_EN undefined: out_perf_stall_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-023 base=0x10, num=4, grant=1, ready=1, 3-cycle responder -> requests to 0x10..0x13, 4 tokens in order, last on 4th, done pulse once.
REQ-024 base=0xFE, num=4 -> addresses 0xFE,0xFF,0x00,0x01.
REQ-025 num=8, ready=0 -> exactly 4 requests issued then stall; ready=1 -> remaining 4 issue, 8 tokens delivered; perf count >0 with macro, 0 without.
REQ-026 grant toggling every cycle, num=6 -> requests only in grant cycles, 6 tokens, data intact.
REQ-027 num=0 -> no requests, out_done one cycle after start, busy never high; start during busy -> ignored.
REQ-028 rst asserted with 2 requests outstanding -> all outputs 0 immediately; late valids after release produce no out_tok_valid.
